reg_file_2r1w: RTL and testbench

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

---
 rtl/reg_file_2r1w_pkg.sv | 12 +
 rtl/reg_file_2r1w_if.sv | 42 ++++
 rtl/reg_file_2r1w_cell.sv | 21 ++
 rtl/reg_file_2r1w.sv | 81 ++++++++
 tb/tb_reg_file_2r1w.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// Shared processor package: register-file sizing defaults
// and the address-width derivation used by the RTL.
package reg_file_2r1w_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Write port plus two registered read ports of the
// register file, bundled with master/slave modports.
interface reg_file_2r1w_if
  import reg_file_2r1w_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS
);

  localparam int ADDR_W = addr_w(NUM_REGS);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic              valid_a;

  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              valid_b;

  modport master (
    output we, waddr, wdata,
    output re_a, raddr_a,
    output re_b, raddr_b,
    input  rdata_a, valid_a,
    input  rdata_b, valid_b
  );

  modport slave (
    input  we, waddr, wdata,
    input  re_a, raddr_a,
    input  re_b, raddr_b,
    output rdata_a, valid_a,
    output rdata_b, valid_b
  );

endinterface

// File: rtl/reg_file_2r1w_cell.sv
// One register-file entry: load-enabled register
// with active-low asynchronous clear.
module regfile_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read one-write register file, r0 hardwired to zero,
// registered read ports with write-to-read bypass.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input logic            clk,
  input logic            reset,
  reg_file_2r1w_if.slave bus
);

  localparam int ADDR_W = addr_w(NUM_REGS);
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  live;

  // Decode space is padded to a power of two; r0 and any
  // slot past NUM_REGS are constant zero and never written.
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      if (i == 0 || i >= NUM_REGS) begin : g_zero
        assign regs[i] = '0;
        assign live[i] = 1'b0;
      end else begin : g_cell
        assign live[i] = 1'b1;
        regfile_cell #(
          .W(DATA_W)
        ) u_cell (
          .clk   (clk),
          .clr_n (reset),
          .en    (bus.we && bus.waddr == ADDR_W'(i)),
          .d     (bus.wdata),
          .q     (regs[i])
        );
      end
    end
  endgenerate

  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  always_comb begin
    hit_a = bus.we && (bus.waddr == bus.raddr_a)
            && live[bus.raddr_a];
    hit_b = bus.we && (bus.waddr == bus.raddr_b)
            && live[bus.raddr_b];
    rd_a  = hit_a ? bus.wdata : regs[bus.raddr_a];
    rd_b  = hit_b ? bus.wdata : regs[bus.raddr_b];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata_a <= '0;
      bus.valid_a <= 1'b0;
    end else begin
      bus.valid_a <= bus.re_a;
      if (bus.re_a) begin
        bus.rdata_a <= rd_a;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata_b <= '0;
      bus.valid_b <= 1'b0;
    end else begin
      bus.valid_b <= bus.re_b;
      if (bus.re_b) begin
        bus.rdata_b <= rd_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: directed vectors
// queue expected read results, a monitor pops and checks.
module tb_reg_file_2r1w;

  logic clk;
  logic reset;

  reg_file_2r1w_if #(.DATA_W(32), .NUM_REGS(32)) bus ();

  reg_file_2r1w dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        va;
    logic [31:0] da;
    logic        vb;
    logic [31:0] db;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h want %08h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per driven cycle,
  // checked 1 time unit after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("valid_a", 32'(bus.valid_a), 32'(e.va));
        chk("rdata_a", bus.rdata_a, e.da);
        chk("valid_b", 32'(bus.valid_b), 32'(e.vb));
        chk("rdata_b", bus.rdata_b, e.db);
      end else if (bus.valid_a || bus.valid_b) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: a=%0b b=%0b want 0 at %0t",
                 bus.valid_a, bus.valid_b, $time);
      end
    end
  end

  task automatic idle();
    bus.we      = 1'b0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.re_a    = 1'b0;
    bus.raddr_a = '0;
    bus.re_b    = 1'b0;
    bus.raddr_b = '0;
  endtask

  task automatic cyc(input logic        we,
                     input logic [4:0]  wa,
                     input logic [31:0] wd,
                     input logic        rea,
                     input logic [4:0]  ra,
                     input logic        reb,
                     input logic [4:0]  rb,
                     input logic        eva,
                     input logic [31:0] eda,
                     input logic        evb,
                     input logic [31:0] edb);
    exp_t e;
    @(negedge clk);
    bus.we      = we;
    bus.waddr   = wa;
    bus.wdata   = wd;
    bus.re_a    = rea;
    bus.raddr_a = ra;
    bus.re_b    = reb;
    bus.raddr_b = rb;
    e.va = eva;
    e.da = eda;
    e.vb = evb;
    e.db = edb;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();

    // Writes and reads while held in reset must leave nothing behind
    repeat (5) begin
      @(negedge clk);
      bus.we      = 1'b1;
      bus.waddr   = 5'($urandom_range(1, 31));
      bus.wdata   = $urandom;
      bus.re_a    = 1'b1;
      bus.raddr_a = 5'($urandom);
      bus.re_b    = 1'b1;
      bus.raddr_b = 5'($urandom);
    end
    #1;
    chk("rst_rdata_a", bus.rdata_a, 32'h0);
    chk("rst_rdata_b", bus.rdata_b, 32'h0);
    chk("rst_valid_a", 32'(bus.valid_a), 32'h0);
    chk("rst_valid_b", 32'(bus.valid_b), 32'h0);
    @(negedge clk);
    idle();
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 5'd0, 32'h0,
          1'b1, 5'(i), 1'b1, 5'(31 - i),
          1'b1, 32'h0, 1'b1, 32'h0);
    end

    // we  wa  wd            rea ra  reb rb   va da            vb db
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  0, 32'h0,        0, 32'h0);
    cyc(0, 0, 32'h0,        1, 5, 0, 0,  1, 32'hDEADBEEF, 0, 32'h0);
    cyc(1, 7, 32'h12345678, 1, 7, 1, 7,  1, 32'h12345678, 1, 32'h12345678);
    cyc(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0,  0, 32'h12345678, 1, 32'h0);
    cyc(0, 0, 32'h0,        0, 0, 1, 0,  0, 32'h12345678, 1, 32'h0);
    cyc(1, 3, 32'hA5A5A5A5, 0, 0, 0, 0,  0, 32'h12345678, 0, 32'h0);
    cyc(0, 0, 32'h0,        1, 3, 1, 5,  1, 32'hA5A5A5A5, 1, 32'hDEADBEEF);
    cyc(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'hA5A5A5A5, 0, 32'hDEADBEEF);
    cyc(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'hA5A5A5A5, 0, 32'hDEADBEEF);
    cyc(1, 9, 32'h11111111, 1, 5, 1, 9,  1, 32'hDEADBEEF, 1, 32'h11111111);
    cyc(1, 9, 32'h22222222, 1, 9, 1, 7,  1, 32'h22222222, 1, 32'h12345678);
    cyc(0, 0, 32'h0,        1, 9, 1, 9,  1, 32'h22222222, 1, 32'h22222222);
    cyc(1, 31, 32'h80000001, 0, 0, 1, 3, 0, 32'h22222222, 1, 32'hA5A5A5A5);
    cyc(0, 0, 32'h0,        1, 31, 1, 0, 1, 32'h80000001, 1, 32'h0);
    cyc(0, 0, 32'h0,        1, 5, 0, 0,  1, 32'hDEADBEEF, 0, 32'h0);

    // Reset lands between edges with a read of r5 pending
    @(negedge clk);
    bus.we      = 1'b0;
    bus.re_a    = 1'b1;
    bus.raddr_a = 5'd5;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_rdata_a", bus.rdata_a, 32'h0);
    chk("mid_rst_valid_a", 32'(bus.valid_a), 32'h0);
    repeat (2) @(negedge clk);
    idle();
    reset = 1'b1;

    cyc(0, 0, 32'h0,        1, 5, 1, 3,  1, 32'h0, 1, 32'h0);
    cyc(0, 0, 32'h0,        1, 31, 1, 9, 1, 32'h0, 1, 32'h0);
    cyc(0, 0, 32'h0,        0, 0, 0, 0,  0, 32'h0, 0, 32'h0);

    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
